// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM port shared by IF (4-byte reads) and LS
// (1/2/4-byte loads and stores). Read data is assembled little-endian.
// Optional macro MEM_RR_EN: round-robin tie-break instead of LS_PRIO.
// Ports: clk, rst (async, active-high)
//   IF : if_req, if_addr, if_flush -> if_done, if_data
//   LS : ls_req, ls_we, ls_size, ls_addr, ls_wdata -> ls_done, ls_rdata
//   RAM: mem_din in; mem_dout, mem_a, mem_wr out (all outputs registered)
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter bit LS_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {
    IDLE, IF_RD, LS_RD, LS_WR
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        num_q, num_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_done_q, if_done_d;
  logic              ls_done_q, ls_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;

  logic              if_req_m, ls_req_m;
  logic              ls_win, gnt_if, gnt_ls;
  logic              issue, last_rd, last_wr;
  logic [2:0]        ls_n;
  logic [1:0]        cap_idx;
  logic [31:0]       rbuf_cap;
  logic [ADDR_W-1:0] addr_k;

`ifdef MEM_RR_EN
  // rr_q = 1: LS wins the next tie
  logic rr_q, rr_d;
  assign ls_win = rr_q;

  always_comb begin
    rr_d = rr_q;
    if (state_q == IF_RD && (if_flush || last_rd))
      rr_d = 1'b0 == 1'b0;
    else if ((state_q == LS_RD && last_rd) ||
             (state_q == LS_WR && last_wr))
      rr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b1;
    else     rr_q <= rr_d;
  end
`else
  assign ls_win = LS_PRIO;
`endif

  // Requester just served is masked during its done cycle.
  always_comb begin
    if_req_m = if_req & ~if_done_q & ~if_flush;
    ls_req_m = ls_req & ~ls_done_q;
    gnt_ls   = ls_req_m & (~if_req_m | ls_win);
    gnt_if   = if_req_m & ~gnt_ls;
    unique case (ls_size)
      2'd0:    ls_n = 3'd1;
      2'd1:    ls_n = 3'd2;
      default: ls_n = 3'd4;
    endcase
    // cnt_q counts edges since grant; byte k lands at cnt_q == k+2
    issue    = cnt_q < num_q;
    last_rd  = cnt_q == num_q + 3'd1;
    last_wr  = cnt_q == num_q;
    cap_idx  = cnt_q[1:0] - 2'd2;
    addr_k   = addr_q + {{(ADDR_W-3){1'b0}}, cnt_q};
    rbuf_cap = rbuf_q;
    if (cnt_q >= 3'd2)
      rbuf_cap[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_ls)      state_d = ls_we ? LS_WR : LS_RD;
        else if (gnt_if) state_d = IF_RD;
      end
      IF_RD: if (if_flush || last_rd) state_d = IDLE;
      LS_RD: if (last_rd) state_d = IDLE;
      LS_WR: if (last_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q + 3'd1;
    num_d      = num_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    mem_a_d    = '0;
    mem_dout_d = '0;
    mem_wr_d   = 1'b0;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (gnt_ls || gnt_if) begin
          cnt_d   = 3'd1;
          rbuf_d  = '0;
          num_d   = gnt_ls ? ls_n : 3'd4;
          addr_d  = gnt_ls ? ls_addr : if_addr;
          wdata_d = ls_wdata;
          mem_a_d = addr_d;
          if (gnt_ls && ls_we) begin
            mem_dout_d = ls_wdata[7:0];
            mem_wr_d   = 1'b1;
          end
        end
      end
      IF_RD, LS_RD: begin
        rbuf_d = rbuf_cap;
        if (issue) mem_a_d = addr_k;
        // flush beats a coincident final edge
        if (state_q == IF_RD && if_flush) begin
          mem_a_d = '0;
        end else if (last_rd) begin
          if (state_q == IF_RD) begin
            if_done_d = 1'b1;
            if_data_d = rbuf_cap;
          end else begin
            ls_done_d  = 1'b1;
            ls_rdata_d = rbuf_cap;
          end
        end
      end
      LS_WR: begin
        if (issue) begin
          mem_a_d    = addr_k;
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
        end
        if (last_wr) ls_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      num_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks with a queue scoreboard and a
// registered byte RAM model (4 KiB, address wraps on low 12 bits).
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int total;
  int bad;
  logic [31:0] if_exp[$];
  logic [31:0] ls_exp[$];
  logic [31:0] wr_exp[$];
  logic [31:0] if_last;

  mem_arbiter #(.ADDR_W(32), .LS_PRIO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(int a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h10;
      32'h103: return 8'h00;
      32'h007: return 8'h80;
      32'h200: return 8'hAA;
      32'h201: return 8'hBB;
      32'h202: return 8'hCC;
      32'h203: return 8'hDD;
      32'h040: return 8'h11;
      32'h041: return 8'h22;
      32'h042: return 8'h33;
      32'h043: return 8'h44;
      32'hFFF: return 8'h5A;
      32'h000: return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] ram [0:4095];
  bit ram_ready;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i);
      ram_ready <= 1'b1;
    end else if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
    end
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (mem_a !== 32'h0 || mem_dout !== 8'h0 || mem_wr !== 1'b0) begin
      bad++;
      $display("FAIL reset_mem got a=%h d=%h wr=%b want 0/0/0",
               mem_a, mem_dout, mem_wr);
    end
    total++;
    if (if_done !== 1'b0 || ls_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done got if=%b ls=%b want 0/0", if_done, ls_done);
    end
    total++;
    if (if_data !== 32'h0 || ls_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got if=%h ls=%h want 0/0", if_data, ls_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_if_read();
    int done_at;
    logic [31:0] e;
    logic [31:0] ea;
    if_exp.push_back(32'h00100513);
    if_addr = 32'h100;
    if_req  = 1'b1;
    done_at = 0;
    for (int j = 1; j <= 10 && done_at == 0; j++) begin
      @(negedge clk);
      if (j <= 4) begin
        ea = 32'h100 + 32'(j - 1);
        total++;
        if (mem_a !== ea || mem_wr !== 1'b0) begin
          bad++;
          $display("FAIL if_rd_addr j=%0d got a=%h wr=%b want a=%h wr=0",
                   j, mem_a, mem_wr, ea);
        end
      end
      if (if_done === 1'b1) done_at = j;
    end
    if_req = 1'b0;
    total++;
    if (done_at != 6) begin
      bad++;
      $display("FAIL if_rd_latency got %0d want 6", done_at);
    end
    if (if_exp.size() > 0) begin
      e = if_exp.pop_front();
      if_last = e;
      total++;
      if (done_at == 0 || if_data !== e) begin
        bad++;
        $display("FAIL if_rd_data got %h want %h", if_data, e);
      end
    end
    @(negedge clk);
    total++;
    if (if_done !== 1'b0 || mem_a !== 32'h0) begin
      bad++;
      $display("FAIL if_done_pulse got done=%b a=%h want 0/0", if_done, mem_a);
    end
    if_exp.delete();
  endtask

  task automatic test_ls_store();
    int done_at;
    logic [7:0] eb [4];
    logic [31:0] e;
    logic [31:0] ea;
    logic [31:0] got;
    eb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wr_exp.push_back(32'hDEADBEEF);
    ls_we    = 1'b1;
    ls_size  = 2'd2;
    ls_addr  = 32'h20;
    ls_wdata = 32'hDEADBEEF;
    ls_req   = 1'b1;
    done_at  = 0;
    for (int j = 1; j <= 10 && done_at == 0; j++) begin
      @(negedge clk);
      if (j <= 4) begin
        ea = 32'h20 + 32'(j - 1);
        total++;
        if (mem_a !== ea || mem_dout !== eb[j-1] || mem_wr !== 1'b1) begin
          bad++;
          $display("FAIL st_beat j=%0d got a=%h d=%h wr=%b want a=%h d=%h wr=1",
                   j, mem_a, mem_dout, mem_wr, ea, eb[j-1]);
        end
      end
      if (ls_done === 1'b1) begin
        done_at = j;
        total++;
        if (mem_wr !== 1'b0) begin
          bad++;
          $display("FAIL st_wr_off got wr=%b want 0", mem_wr);
        end
      end
    end
    ls_req = 1'b0;
    ls_we  = 1'b0;
    total++;
    if (done_at != 5) begin
      bad++;
      $display("FAIL st_latency got %0d want 5", done_at);
    end
    if (wr_exp.size() > 0) begin
      e   = wr_exp.pop_front();
      got = {ram[12'h23], ram[12'h22], ram[12'h21], ram[12'h20]};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL st_ram got %h want %h", got, e);
      end
    end
    @(negedge clk);
    wr_exp.delete();
  endtask

  task automatic test_ls_loads();
    int done_at;
    int n;
    logic [1:0] sz;
    logic [31:0] a;
    logic [31:0] ex;
    logic [31:0] e;
    logic [31:0] ea;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: begin sz = 2'd3; a = 32'h40; ex = 32'h44332211; n = 4; end
        1: begin sz = 2'd0; a = 32'h07; ex = 32'h00000080; n = 1; end
        default: begin
          sz = 2'd1; a = 32'hFFFFFFFF; ex = 32'h0000A55A; n = 2;
        end
      endcase
      ls_exp.push_back(ex);
      ls_we   = 1'b0;
      ls_size = sz;
      ls_addr = a;
      ls_req  = 1'b1;
      done_at = 0;
      for (int j = 1; j <= 12 && done_at == 0; j++) begin
        @(negedge clk);
        if (j <= n) begin
          ea = a + 32'(j - 1);
          total++;
          if (mem_a !== ea || mem_wr !== 1'b0) begin
            bad++;
            $display("FAIL ld%0d_addr j=%0d got a=%h wr=%b want a=%h wr=0",
                     t, j, mem_a, mem_wr, ea);
          end
        end
        if (ls_done === 1'b1) done_at = j;
      end
      ls_req = 1'b0;
      total++;
      if (done_at != n + 2) begin
        bad++;
        $display("FAIL ld%0d_latency got %0d want %0d", t, done_at, n + 2);
      end
      if (ls_exp.size() > 0) begin
        e = ls_exp.pop_front();
        total++;
        if (done_at == 0 || ls_rdata !== e) begin
          bad++;
          $display("FAIL ld%0d_data got %h want %h", t, ls_rdata, e);
        end
      end
      @(negedge clk);
      ls_exp.delete();
    end
  endtask

  task automatic test_tie();
    int at [3];
    bit is_if [3];
    int exp_at [3];
    bit exp_if [3];
    int n;
    int ls_cnt;
    logic [31:0] e;
    at     = '{0, 0, 0};
    is_if  = '{1'b0, 1'b0, 1'b0};
    exp_at = '{3, 9, 12};
    exp_if = '{1'b0, 1'b1, 1'b0};
    ls_exp.push_back(32'h80);
    ls_exp.push_back(32'h80);
    if_exp.push_back(32'hDDCCBBAA);
    if_addr = 32'h200;
    ls_we   = 1'b0;
    ls_size = 2'd0;
    ls_addr = 32'h7;
    if_req  = 1'b1;
    ls_req  = 1'b1;
    n = 0;
    ls_cnt = 0;
    for (int j = 1; j <= 30 && n < 3; j++) begin
      @(negedge clk);
      if (j == 1) begin
        total++;
        if (mem_a !== 32'h7) begin
          bad++;
          $display("FAIL tie_first_grant got a=%h want 00000007", mem_a);
        end
      end
      if (ls_done === 1'b1) begin
        at[n] = j;
        is_if[n] = 1'b0;
        n++;
        ls_cnt++;
        if (ls_cnt == 2) ls_req = 1'b0;
        if (ls_exp.size() > 0) begin
          e = ls_exp.pop_front();
          total++;
          if (ls_rdata !== e) begin
            bad++;
            $display("FAIL tie_ls_data got %h want %h", ls_rdata, e);
          end
        end
      end else if (if_done === 1'b1) begin
        at[n] = j;
        is_if[n] = 1'b1;
        n++;
        if_req = 1'b0;
        if (if_exp.size() > 0) begin
          e = if_exp.pop_front();
          if_last = e;
          total++;
          if (if_data !== e) begin
            bad++;
            $display("FAIL tie_if_data got %h want %h", if_data, e);
          end
        end
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (at[k] != exp_at[k] || is_if[k] != exp_if[k]) begin
        bad++;
        $display("FAIL tie_order k=%0d got cyc=%0d if=%0d want cyc=%0d if=%0d",
                 k, at[k], is_if[k], exp_at[k], exp_if[k]);
      end
    end
    @(negedge clk);
    ls_exp.delete();
    if_exp.delete();
  endtask

  task automatic test_flush();
    int ls_at;
    bit if_seen;
    logic [31:0] e;
    ls_exp.push_back(32'h80);
    if_addr = 32'h100;
    if_req  = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (mem_a !== 32'h101) begin
      bad++;
      $display("FAIL flush_pre_addr got %h want 00000101", mem_a);
    end
    if_flush = 1'b1;
    if_req   = 1'b0;
    ls_we    = 1'b0;
    ls_size  = 2'd0;
    ls_addr  = 32'h7;
    ls_req   = 1'b1;
    @(negedge clk);
    total++;
    if (mem_a !== 32'h0 || if_done !== 1'b0) begin
      bad++;
      $display("FAIL flush_abort got a=%h done=%b want 0/0", mem_a, if_done);
    end
    if_flush = 1'b0;
    @(negedge clk);
    total++;
    if (mem_a !== 32'h7) begin
      bad++;
      $display("FAIL flush_ls_grant got a=%h want 00000007", mem_a);
    end
    ls_at = 0;
    if_seen = 1'b0;
    for (int j = 5; j <= 12 && ls_at == 0; j++) begin
      @(negedge clk);
      if (if_done === 1'b1) if_seen = 1'b1;
      if (ls_done === 1'b1) ls_at = j;
    end
    ls_req = 1'b0;
    total++;
    if (ls_at != 6) begin
      bad++;
      $display("FAIL flush_ls_latency got %0d want 6", ls_at);
    end
    if (ls_exp.size() > 0) begin
      e = ls_exp.pop_front();
      total++;
      if (ls_rdata !== e) begin
        bad++;
        $display("FAIL flush_ls_data got %h want %h", ls_rdata, e);
      end
    end
    total++;
    if (if_seen || if_data !== if_last) begin
      bad++;
      $display("FAIL flush_if_quiet got seen=%0d data=%h want 0/%h",
               if_seen, if_data, if_last);
    end
    @(negedge clk);
    if_addr = 32'h40;
    if_req  = 1'b1;
    repeat (5) @(negedge clk);
    if_flush = 1'b1;
    if_req   = 1'b0;
    @(negedge clk);
    total++;
    if (if_done !== 1'b0 || if_data !== if_last) begin
      bad++;
      $display("FAIL flush_final_edge got done=%b data=%h want 0/%h",
               if_done, if_data, if_last);
    end
    if_flush = 1'b0;
    @(negedge clk);
    total++;
    if (if_done !== 1'b0 || mem_a !== 32'h0) begin
      bad++;
      $display("FAIL flush_after got done=%b a=%h want 0/0", if_done, mem_a);
    end
    ls_exp.delete();
  endtask

  task automatic test_reset_mid_store();
    int done_at;
    logic [31:0] e;
    ls_we    = 1'b1;
    ls_size  = 2'd2;
    ls_addr  = 32'h30;
    ls_wdata = 32'h11223344;
    ls_req   = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (mem_a !== 32'h32 || mem_wr !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre got a=%h wr=%b want 00000032/1", mem_a, mem_wr);
    end
    rst = 1'b1;
    #1;
    total++;
    if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0) begin
      bad++;
      $display("FAIL rst_mem_async got a=%h d=%h wr=%b want 0/0/0",
               mem_a, mem_dout, mem_wr);
    end
    total++;
    if (ls_done !== 1'b0 || if_done !== 1'b0 ||
        ls_rdata !== 32'h0 || if_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_out_async got done=%b/%b data=%h/%h want all 0",
               if_done, ls_done, if_data, ls_rdata);
    end
    ls_req  = 1'b0;
    ls_we   = 1'b0;
    if_last = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ls_done !== 1'b0 || mem_wr !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_done got done=%b wr=%b want 0/0", ls_done, mem_wr);
    end
    ls_exp.push_back(32'h00003344);
    ls_size = 2'd2;
    ls_addr = 32'h30;
    ls_req  = 1'b1;
    done_at = 0;
    for (int j = 1; j <= 12 && done_at == 0; j++) begin
      @(negedge clk);
      if (ls_done === 1'b1) done_at = j;
    end
    ls_req = 1'b0;
    total++;
    if (done_at != 6) begin
      bad++;
      $display("FAIL rst_reload_latency got %0d want 6", done_at);
    end
    if (ls_exp.size() > 0) begin
      e = ls_exp.pop_front();
      total++;
      if (ls_rdata !== e) begin
        bad++;
        $display("FAIL rst_reload_data got %h want %h", ls_rdata, e);
      end
    end
    @(negedge clk);
    ls_exp.delete();
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    if_last  = 32'h0;
    rst      = 1'b1;
    if_req   = 1'b0;
    if_addr  = 32'h0;
    if_flush = 1'b0;
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    ls_size  = 2'd0;
    ls_addr  = 32'h0;
    ls_wdata = 32'h0;
    test_reset();
    test_if_read();
    test_ls_store();
    test_ls_loads();
    test_tie();
    test_flush();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
